ppu_clock_ctrl: RTL and testbench

PPU_CLOCK_CTRL -- requirements
Module: ppu_clock_ctrl

---
 rtl/ppu_pkg.sv | 18 +
 rtl/edge_detect.sv | 22 ++
 rtl/ppu_clock_ctrl.sv | 100 ++++++++++
 tb/tb_ppu_clock_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared opcode and state encodings for the PPU clock controller.
// Pure type/constant definitions; no logic, no latency, no flow control.
package ppu_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_RUN  = 2'd1,
        OP_STOP = 2'd2,
        OP_STEP = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2
    } state_e;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a slow synchronously sampled level: rise is combinational from
// the current sample against the registered previous one; no backpressure.
module edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/ppu_clock_ctrl.sv
// Run/stop/single-step controller gating the PPU XIN clock, with an XIN-count breakpoint.
// Status outputs lag the state by one cycle; commands are always accepted (ready tied high).
module ppu_clock_ctrl
    import ppu_pkg::*;
#(
    parameter int STEP_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              xin_i,
    input  logic [31:0]       xin_counter_i,
    output logic              xin_stall_o,
    input  logic              cmd_valid_i,
    input  logic [1:0]        cmd_op_i,
    input  logic [STEP_W-1:0] cmd_count_i,
    output logic              cmd_ready_o,
    input  logic              bp_enable_i,
    input  logic [31:0]       bp_value_i,
    output logic              running_o,
    output logic              done_o,
    output logic              bp_hit_o
);

    state_e            state, state_nxt;
    logic [STEP_W-1:0] remain, remain_nxt;
    logic              done_nxt, bp_nxt;
    logic              xin_rise;
    logic              cmd_run, cmd_stop, cmd_step;
    logic              step_last, bp_match;

    edge_detect u_edge (
        .clock (clock),
        .reset (reset),
        .level (xin_i),
        .rise  (xin_rise)
    );

    assign cmd_ready_o = 1'b1;
    assign cmd_run     = cmd_valid_i && (cmd_op_i == OP_RUN);
    assign cmd_stop    = cmd_valid_i && (cmd_op_i == OP_STOP);
    assign cmd_step    = cmd_valid_i && (cmd_op_i == OP_STEP);

    assign step_last = (state == ST_STEPPING) && xin_rise && (remain == STEP_W'(1));
    // Gated by state so a breakpoint only fires once; it re-arms on leaving STOPPED.
    assign bp_match  = bp_enable_i && (xin_counter_i == bp_value_i) && (state != ST_STOPPED);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_STOPPED;
            remain      <= '0;
            xin_stall_o <= 1'b1;
            running_o   <= 1'b0;
            done_o      <= 1'b0;
            bp_hit_o    <= 1'b0;
        end else begin
            state       <= state_nxt;
            remain      <= remain_nxt;
            xin_stall_o <= (state == ST_STOPPED);
            running_o   <= (state != ST_STOPPED);
            done_o      <= done_nxt;
            bp_hit_o    <= bp_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        done_nxt   = 1'b0;
        bp_nxt     = 1'b0;

        if ((state == ST_STEPPING) && xin_rise) begin
            remain_nxt = remain - STEP_W'(1);
        end

        if (cmd_stop) begin
            state_nxt = ST_STOPPED;
        end else if (bp_match) begin
            state_nxt = ST_STOPPED;
            bp_nxt    = 1'b1;
            done_nxt  = step_last;
        end else if (step_last) begin
            state_nxt = ST_STOPPED;
            done_nxt  = 1'b1;
        end else if (cmd_run) begin
            state_nxt = ST_RUNNING;
        end else if (cmd_step && (state == ST_STOPPED)) begin
            if (cmd_count_i != '0) begin
                state_nxt  = ST_STEPPING;
                remain_nxt = cmd_count_i;
            end else begin
                done_nxt = 1'b1;
            end
        end

        if (state_nxt != ST_STEPPING) begin
            remain_nxt = '0;
        end
    end

endmodule

// File: tb/tb_ppu_clock_ctrl.sv
// Bench for ppu_clock_ctrl: a ppu_clock model drives XIN, stimulus queues expected pulses,
// and a negedge monitor pops and compares every done/bp_hit pulse.
module tb_ppu_clock_ctrl;

    localparam logic [1:0] NOP  = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] STOP = 2'd2;
    localparam logic [1:0] STEP = 2'd3;

    logic        clock;
    logic        reset;
    logic        xin = 1'b0;
    logic [31:0] xin_cnt = 32'd0;
    logic        stall;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_count;
    logic        cmd_ready;
    logic        bp_enable;
    logic [31:0] bp_value;
    logic        running;
    logic        done;
    logic        bp_hit;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ph     = 0;

    typedef struct {
        logic done;
        logic bp;
        int   cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    ppu_clock_ctrl #(.STEP_W(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .xin_i         (xin),
        .xin_counter_i (xin_cnt),
        .xin_stall_o   (stall),
        .cmd_valid_i   (cmd_valid),
        .cmd_op_i      (cmd_op),
        .cmd_count_i   (cmd_count),
        .cmd_ready_o   (cmd_ready),
        .bp_enable_i   (bp_enable),
        .bp_value_i    (bp_value),
        .running_o     (running),
        .done_o        (done),
        .bp_hit_o      (bp_hit)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc++;

    // ppu_clock model: XIN toggles every 2 enabled clocks, counter bumps on each rising edge.
    always @(posedge clock) begin
        if (stall === 1'b0) begin
            if (ph == 1) begin
                ph <= 0;
                xin <= ~xin;
                if (!xin) xin_cnt <= xin_cnt + 32'd1;
            end else begin
                ph <= ph + 1;
            end
        end
    end

    task automatic check1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset === 1'b0 && (done === 1'b1 || bp_hit === 1'b1)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_pulse: done=%b bp_hit=%b at cycle %0d, want no pulse",
                         done, bp_hit, cyc);
            end else begin
                mon_e = sb.pop_front();
                check1("pulse_done", done, mon_e.done);
                check1("pulse_bp_hit", bp_hit, mon_e.bp);
                if (mon_e.cyc >= 0) check32("pulse_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic push(logic d, logic b, int c);
        exp_t e;
        e.done = d;
        e.bp   = b;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Called at a negedge; the command is sampled on the following posedge.
    task automatic issue(logic [1:0] op, logic [15:0] n);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = n;
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_op    = NOP;
        cmd_count = 16'd0;
    endtask

    task automatic wait_drain(string name, int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d pulses pending after %0d cycles, want 0",
                     name, sb.size(), n);
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c0;
        logic [31:0] c1;
        int n;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = NOP;
        cmd_count = 16'd0;
        bp_enable = 1'b0;
        bp_value  = 32'd0;

        // Reset for 3 cycles.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check1("rst_hold_stall", stall, 1'b1);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check1("rst_stall", stall, 1'b1);
        check1("rst_running", running, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_bp_hit", bp_hit, 1'b0);
        check1("rst_ready", cmd_ready, 1'b1);
        check32("rst_counter_frozen", xin_cnt, 32'd0);

        // STEP 5: exactly five XIN rising edges then one done pulse.
        c0 = xin_cnt;
        push(1'b1, 1'b0, -1);
        issue(STEP, 16'd5);
        repeat (2) @(negedge clock);
        check1("step5_running", running, 1'b1);
        check1("step5_stall_low", stall, 1'b0);
        wait_drain("step5", 100);
        repeat (6) @(negedge clock);
        check32("step5_edges", xin_cnt - c0, 32'd5);
        check1("step5_stall", stall, 1'b1);
        check1("step5_stopped", running, 1'b0);

        // Breakpoint at 100 while running.
        bp_value  = 32'd100;
        bp_enable = 1'b1;
        push(1'b0, 1'b1, -1);
        issue(RUN, 16'd0);
        wait_drain("bp100", 800);
        repeat (10) @(negedge clock);
        check32("bp100_counter", xin_cnt, 32'd100);
        check1("bp100_stall", stall, 1'b1);
        check1("bp100_stopped", running, 1'b0);
        bp_enable = 1'b0;

        // Breakpoint coincident with the last step edge.
        c0 = xin_cnt;
        bp_value  = c0 + 32'd3;
        bp_enable = 1'b1;
        push(1'b1, 1'b1, -1);
        issue(STEP, 16'd3);
        wait_drain("coinc", 100);
        repeat (4) @(negedge clock);
        check32("coinc_edges", xin_cnt - c0, 32'd3);
        check1("coinc_stall", stall, 1'b1);
        check1("coinc_stopped", running, 1'b0);
        bp_enable = 1'b0;

        // Abort a long step with STOP after 10 edges: no done pulse.
        c0 = xin_cnt;
        issue(STEP, 16'd1000);
        n = 0;
        while (xin_cnt != c0 + 32'd10 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check32("abort_reach10", xin_cnt - c0, 32'd10);
        issue(STOP, 16'd0);
        repeat (3) @(negedge clock);
        check1("abort_stall", stall, 1'b1);
        check1("abort_stopped", running, 1'b0);
        c1 = xin_cnt;
        repeat (10) @(negedge clock);
        check32("abort_frozen", xin_cnt, c1);

        // STEP 0: done on the next cycle, stall never drops.
        push(1'b1, 1'b0, cyc + 1);
        issue(STEP, 16'd0);
        for (int i = 0; i < 4; i++) begin
            check1("step0_stall", stall, 1'b1);
            @(negedge clock);
        end
        wait_drain("step0", 10);

        // Async reset mid-RUN, asserted between clock edges.
        issue(RUN, 16'd0);
        repeat (6) @(negedge clock);
        check1("arst_pre_running", running, 1'b1);
        #2 reset = 1'b1;
        #1;
        check1("arst_stall_now", stall, 1'b1);
        check1("arst_running_now", running, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        c1 = xin_cnt;
        repeat (8) @(negedge clock);
        check1("arst_after_stall", stall, 1'b1);
        check1("arst_after_running", running, 1'b0);
        check32("arst_frozen", xin_cnt, c1);

        // Reset mid-STEPPING abandons the step silently.
        issue(STEP, 16'd2);
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(negedge clock);
        check1("rstep_stall", stall, 1'b1);
        check1("rstep_stopped", running, 1'b0);

        check32("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
